// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that funnels several writeback sources onto the single
// register-file write port through a one-entry registered output stage.
module regfile_write_arbiter #(
  parameter int REQS  = 2,
  parameter int DEPTH = 32,
  parameter int BITS  = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [0:REQS-1]        req_valid,
  input  logic [0:REQS*AW-1]     req_addr,
  input  logic [0:REQS*BITS-1]   req_data,
  output logic [0:REQS-1]        req_ready,
  output logic [AW-1:0]          addressw,
  output logic [BITS-1:0]        writeData,
  output logic                   writeEn,
  output logic [DEPTH-1:0]       pending_mask,
  output logic [PW-1:0]          rr_ptr
);

  logic [0:REQS-1]  grant_s;
  logic             found_s;
  logic [PW-1:0]    gidx_s;
  logic [AW-1:0]    gaddr_s;
  logic [BITS-1:0]  gdata_s;
  logic [PW-1:0]    ptr_next_s;

  logic [PW-1:0]    rr_ptr_r;
  logic             we_r;
  logic [AW-1:0]    addr_r;
  logic [BITS-1:0]  data_r;

  // Grant search: walk offsets from rr_ptr so the closest valid requester wins.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    gidx_s  = '0;
    gaddr_s = '0;
    gdata_s = '0;
    if (!rst && !hold) begin
      for (int k = 0; k < REQS; k++) begin
        for (int i = 0; i < REQS; i++) begin
          if (!found_s && req_valid[i] && (i == ((int'(rr_ptr_r) + k) % REQS))) begin
            found_s    = 1'b1;
            grant_s[i] = 1'b1;
            gidx_s     = PW'(i);
            gaddr_s    = req_addr[i*AW +: AW];
            gdata_s    = req_data[i*BITS +: BITS];
          end else begin
            grant_s[i] = grant_s[i];
          end
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  // Next priority is the requester just after the winner, wrapping at REQS.
  always_comb begin
    ptr_next_s = '0;
    if (gidx_s == PW'(REQS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gidx_s + PW'(1);
    end
  end

  // Output stage and round-robin pointer; x0 writes complete but never pulse writeEn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else if (found_s) begin
      rr_ptr_r <= ptr_next_s;
      if (gaddr_s != '0) begin
        we_r   <= 1'b1;
        addr_r <= gaddr_s;
        data_r <= gdata_s;
      end else begin
        we_r   <= 1'b0;
      end
    end else begin
      we_r <= 1'b0;
    end
  end

  // Pending-write decode of the staged address for hazard detection.
  always_comb begin
    pending_mask = '0;
    if (we_r) begin
      pending_mask[addr_r] = 1'b1;
    end else begin
      pending_mask = '0;
    end
  end

  assign req_ready = grant_s;
  assign addressw  = addr_r;
  assign writeData = data_r;
  assign writeEn   = we_r;
  assign rr_ptr    = rr_ptr_r;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (addressw/writeData/writeEn) among REQS writeback sources, e.g. ALU writeback and load unit. It performs round-robin arbitration with a valid/ready handshake and registers the winning write into a one-entry output stage. Writes to x0 are suppressed. A pending-write mask is exported for hazard detection. It sits between the writeback sources and the register file write port.

Parameters:
REQS, 2, number of write requesters (>=2)
DEPTH, 32, register count; AW = $clog2(DEPTH)
BITS, 64, data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
hold  input  1  1 = grant nothing this cycle; output stage still drains
req_valid  input  REQS  per-requester write request
req_addr  input  REQS*AW  requester i uses bits [i*AW : i*AW+AW-1]
req_data  input  REQS*BITS  requester i uses bits [i*BITS : i*BITS+BITS-1]
req_ready  output  REQS  one-hot grant; a transfer occurs when valid&ready
addressw  output  AW  register-file write address (registered)
writeData  output  BITS  register-file write data (registered)
writeEn  output  1  register-file write enable (registered)
pending_mask  output  DEPTH  bit r = 1 while a write to register r is in the output stage
rr_ptr  output  $clog2(REQS)  current highest-priority requester (debug)

Behaviour:
- Reset (async, takes effect immediately): writeEn=0, addressw=0, writeData=0, pending_mask=0, rr_ptr=0. req_ready is 0 while rst=1.
- Ports are ascending-indexed [0:N-1]. Bit 0 of req_valid/req_ready is requester 0.
- Grant (combinational): if hold=0, search requesters starting at rr_ptr and wrapping modulo REQS. The first one with req_valid=1 gets req_ready=1; all others get 0. If none is valid, or hold=1, req_ready is all zeros.
- At most one requester is granted per cycle. The register file accepts every write, so the stage never backpressures and no cycle is spent stalled.
- Pointer update: on a cycle with a grant to requester g, rr_ptr <= (g+1) mod REQS at the clock edge. With no grant, rr_ptr holds.
- Output stage, at the clock edge after a grant to g with address a:
  - if a != 0: writeEn<=1, addressw<=a, writeData<=data_g
  - if a == 0: writeEn<=0, addressw/writeData hold. The handshake still completes and the rr_ptr update still happens.
- With no grant at an edge: writeEn<=0; addressw and writeData hold their last values.
- Latency: a request granted in cycle N drives writeEn in cycle N+1. The register file captures it at the end of cycle N+1. writeEn is a single-cycle pulse per accepted write; back-to-back grants give a continuous writeEn.
- pending_mask: combinational decode. The bit for addressw is 1 iff writeEn=1; all other bits are 0. The mask is never set for x0.
- Requesters must hold addr and data stable while valid=1 and ready=0. The block does not check this.
- An unmatched valid=1 request is never dropped. It waits, and round-robin bounds the wait to REQS-1 grants.
- hold asserted mid-stream: the stage drains in the next cycle (writeEn pulses once if the prior cycle granted), then writeEn stays 0 until hold drops.
- Reset mid-operation: the staged write is discarded (writeEn forced 0 immediately), and rr_ptr returns to 0.

Test Plan:
- Reset: assert rst with req_valid=2'b11 -> req_ready=00, writeEn=0, pending_mask=0. Release rst -> requester 0 granted first (rr_ptr=0).
- Alternation: both requesters hold valid continuously (r0 addr 5 data 0xA, r1 addr 6 data 0xB) -> grants alternate 0,1,0,1. writeEn stays high; addressw sequence is 5,6,5,6, each one cycle after its grant.
- x0 suppression: r1 alone requests addr 0 data 0xFFFF -> req_ready[1]=1 for one cycle, next cycle writeEn=0 and pending_mask=0, and rr_ptr becomes 0.
- Pending mask: single write to addr 31 -> next cycle pending_mask has only bit 31 set and writeEn=1. The following idle cycle -> pending_mask=0.
- Hold: grant r0 (addr 3) in cycle N, hold=1 from cycle N+1 for 3 cycles with both requesters valid -> writeEn=1 only in N+1 and req_ready=00 during hold. On release, requester 1 is granted first.
- Async reset mid-write: rst pulsed between clock edges while writeEn=1 -> writeEn falls immediately without waiting for a clock edge, and the register file sees no write.
